mem_copy_dma: RTL and testbench
===============================

Name: mem_copy_dma

Overview:
- Memory-side initiator for the processor's data memory: a block-copy engine that drives the memory's address, write-enable and write-data inputs and consumes its read-data output.
- Copies LEN consecutive 64-bit words from SRC to DST with memmove semantics, so overlapping ranges are safe.
- Sits beside the datapath. It owns the data memory bus while busy, and the top level muxes its bus against the processor's load/store path using busy.

Parameters:
- DEPTH, 32, number of words in the data memory.
- ADDR_W, 64, width of the memory address bus.
- DATA_W, 64, width of a memory word.
- LEN_W, 6, width of the length field; must hold DEPTH.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word index.
- dst_addr  in  ADDR_W  first destination word index.
- length  in  LEN_W  number of words to copy.
- address  out  ADDR_W  memory address (word index).
- WE_mem  out  1  memory write enable.
- dIN  out  DATA_W  memory write data.
- dout  in  DATA_W  memory read data; combinational from address, no registered latency.
- busy  out  1  high from the cycle after accepted start through the last write.
- done  out  1  one-cycle pulse when a copy completes, including length 0.
- error  out  1  one-cycle pulse when a request is rejected.
- words_left  out  LEN_W  remaining words; debug and verification visibility.

Behaviour:
- Reset (async, any state): state=IDLE; address=0, WE_mem=0, dIN=0, busy=0, done=0, error=0, words_left=0. A copy interrupted by reset is abandoned; words already written stay written.
- FSM states: IDLE, CHECK, RD, WR, FIN.
- IDLE:
  - On start=1, latch src, dst and length into registers, then go to CHECK.
  - Inputs are not sampled afterwards.
  - WE_mem=0.
- CHECK (1 cycle):
  - Compute src+length and dst+length at ADDR_W+1 bits, so there is no wrap.
  - If either sum > DEPTH: pulse error and return to IDLE. No memory write occurs.
  - Else if length==0: go to FIN.
  - Else set dir=DESC when dst>src && dst<src+length, otherwise ASC.
  - Initialise the index: ASC gives 0, DESC gives length-1.
  - Set words_left=length, then go to RD.
- RD: drive address=src+idx with WE_mem=0. Capture dout into the data register at posedge, then go to WR.
- WR:
  - Drive address=dst+idx, dIN=data register, WE_mem=1.
  - At posedge: words_left decrements and idx moves +1 (ASC) or -1 (DESC).
  - If words_left becomes 0, go to FIN; else go to RD.
- FIN: pulse done for one cycle, then go to IDLE.
- Throughput: 2 cycles per word. Total from the start cycle to the done pulse is 2*length+2 cycles.
- busy=1 in CHECK, RD, WR and FIN.
- start while busy: ignored, not queued.
- src==dst: a legal copy, performed normally; it rewrites the same values.
- WE_mem is asserted only in WR. It is never high in the same cycle as a read capture.
- address in IDLE holds its last value. WE_mem=0 in IDLE makes this harmless.

Decomposition:
- Shared package mem_pkg holds:
  - DEPTH, ADDR_W, DATA_W, LEN_W;
  - the state enum {IDLE, CHECK, RD, WR, FIN};
  - the direction enum {ASC, DESC}.
- No sub-module. The bounds/overlap check is a small combinational function in the package, range_ok(base, len).

Test Plan (memory preloaded with 0, 10, 20, 30, 40, -10 at words 0..5):
- Forward copy, src=1 dst=10 len=3 -> mem[10..12] = 10, 20, 30; done at cycle 8 after start; WE_mem high exactly 3 cycles.
- Overlap forward, src=0 dst=2 len=4 -> DESC order; mem[2..5] = 0, 10, 20, 30; mem[0..1] unchanged.
- Overlap backward, src=2 dst=0 len=4 -> ASC order; mem[0..3] = 20, 30, 40, -10.
- Bounds reject, src=30 dst=0 len=3 -> error pulse 2 cycles after start; no WE_mem; busy low afterwards.
- Zero length, src=0 dst=5 len=0 -> done pulse 2 cycles after start; WE_mem never asserted.
- Reset mid-copy, assert rst during the 2nd WR of src=1 dst=20 len=4 -> all outputs 0 immediately; mem[20] = 10 and mem[21] = 20 written; mem[22..23] untouched. A new start afterwards is accepted normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizing for the data-memory block-copy engine.
// range_ok is the bounds check used before any memory access.
package mem_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 6;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD,
        WR,
        FIN
    } state_t;

    typedef enum logic {
        ASC,
        DESC
    } dir_t;

    // Widened by one bit so base+len never wraps past the top.
    function automatic logic range_ok(
        input logic [ADDR_W-1:0] base,
        input logic [LEN_W-1:0]  len
    );
        logic [ADDR_W:0] sum;
        sum = {1'b0, base} + {{(ADDR_W+1-LEN_W){1'b0}}, len};
        return sum <= (ADDR_W+1)'(DEPTH);
    endfunction

endpackage

// File: rtl/mem_copy_dma.sv
// Block-copy engine for the data memory with memmove semantics.
// One read and one write cycle per word; direction picked per request.
module mem_copy_dma
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic [ADDR_W-1:0] address,
    output logic              WE_mem,
    output logic [DATA_W-1:0] dIN,
    input  logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_left
);

    state_t            state;
    dir_t              dir;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  idx;

    logic [ADDR_W:0]   src_end;
    logic              overlap;
    logic [LEN_W-1:0]  idx_init;
    logic [LEN_W-1:0]  idx_nxt;
    logic [ADDR_W-1:0] idx_ext;
    logic [ADDR_W-1:0] init_ext;
    logic [ADDR_W-1:0] nxt_ext;
    logic              bad_req;

    // Destination inside the source tail: copy from the top down.
    assign src_end  = {1'b0, src_r}
                    + {{(ADDR_W+1-LEN_W){1'b0}}, len_r};
    assign overlap  = (dst_r > src_r)
                    && ({1'b0, dst_r} < src_end);
    assign idx_init = overlap ? len_r - 1'b1 : '0;
    assign idx_nxt  = (dir == DESC) ? idx - 1'b1 : idx + 1'b1;
    assign idx_ext  = {{(ADDR_W-LEN_W){1'b0}}, idx};
    assign init_ext = {{(ADDR_W-LEN_W){1'b0}}, idx_init};
    assign nxt_ext  = {{(ADDR_W-LEN_W){1'b0}}, idx_nxt};
    assign bad_req  = !range_ok(src_r, len_r)
                    || !range_ok(dst_r, len_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dir        <= ASC;
            src_r      <= '0;
            dst_r      <= '0;
            len_r      <= '0;
            idx        <= '0;
            address    <= '0;
            WE_mem     <= 1'b0;
            dIN        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            words_left <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state)
                IDLE: begin
                    WE_mem <= 1'b0;
                    if (start) begin
                        src_r <= src_addr;
                        dst_r <= dst_addr;
                        len_r <= length;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (bad_req) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (len_r == '0) begin
                        done       <= 1'b1;
                        words_left <= '0;
                        state      <= FIN;
                    end else begin
                        dir        <= overlap ? DESC : ASC;
                        idx        <= idx_init;
                        words_left <= len_r;
                        address    <= src_r + init_ext;
                        state      <= RD;
                    end
                end
                RD: begin
                    address <= dst_r + idx_ext;
                    dIN     <= dout;
                    WE_mem  <= 1'b1;
                    state   <= WR;
                end
                WR: begin
                    WE_mem     <= 1'b0;
                    words_left <= words_left - 1'b1;
                    idx        <= idx_nxt;
                    if (words_left == LEN_W'(1)) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        address <= src_r + nxt_ext;
                        state   <= RD;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma against a 32-word memory model.
// Covers forward, overlapping, rejected, empty and reset-interrupted copies.
module tb_mem_copy_dma;
    import mem_pkg::*;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic [ADDR_W-1:0] address;
    logic              WE_mem;
    logic [DATA_W-1:0] dIN;
    logic [DATA_W-1:0] dout;
    logic              busy;
    logic              done;
    logic              error;
    logic [LEN_W-1:0]  words_left;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic              pre;

    int total;
    int bad;

    mem_copy_dma dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .address    (address),
        .WE_mem     (WE_mem),
        .dIN        (dIN),
        .dout       (dout),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_left (words_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_val(input int i);
        case (i)
            0: return 64'd0;
            1: return 64'd10;
            2: return 64'd20;
            3: return 64'd30;
            4: return 64'd40;
            5: return -64'd10;
            default: return 64'hDEAD_0000 + 64'(i);
        endcase
    endfunction

    assign dout = mem[address[4:0]];

    always @(posedge clk) begin
        if (pre) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= init_val(i);
        end else if (WE_mem) begin
            mem[address[4:0]] <= dIN;
        end
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    task automatic preload;
        @(negedge clk);
        pre = 1'b1;
        @(negedge clk);
        pre = 1'b0;
    endtask

    // Cycle 0 is the start cycle; counts negedges after it.
    task automatic run(input logic [63:0] s,
                       input logic [63:0] d,
                       input logic [5:0]  l,
                       output int dcyc,
                       output int ecyc,
                       output int wes,
                       output logic [63:0] first_wa);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        length   = l;
        start    = 1'b1;
        dcyc     = -1;
        ecyc     = -1;
        wes      = 0;
        first_wa = '1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (WE_mem) begin
                if (wes == 0) first_wa = address;
                wes++;
            end
            if (done)  dcyc = c;
            if (error) ecyc = c;
            if (done || error) break;
        end
        start = 1'b0;
    endtask

    int dc, ec, nw, seen;
    logic [63:0] fa;

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        pre      = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        repeat (2) @(negedge clk);
        chk("rst_address", address, 0);
        chk("rst_we", WE_mem, 0);
        chk("rst_din", dIN, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {done, error}, 0);
        chk("rst_left", words_left, 0);
        rst = 1'b0;

        // forward, disjoint
        preload();
        run(1, 10, 3, dc, ec, nw, fa);
        chk("fwd_done_cyc", dc, 8);
        chk("fwd_we_cnt", nw, 3);
        chk("fwd_first_wa", fa, 10);
        @(negedge clk);
        chk("fwd_busy_after", busy, 0);
        chk("fwd_done_pulse", done, 0);
        chk("fwd_left", words_left, 0);
        chk("fwd_m10", mem[10], 10);
        chk("fwd_m11", mem[11], 20);
        chk("fwd_m12", mem[12], 30);

        // dst above src inside range: top-down
        preload();
        run(0, 2, 4, dc, ec, nw, fa);
        chk("ovf_done_cyc", dc, 10);
        chk("ovf_first_wa", fa, 5);
        chk("ovf_m0", mem[0], 0);
        chk("ovf_m1", mem[1], 10);
        chk("ovf_m2", mem[2], 0);
        chk("ovf_m3", mem[3], 10);
        chk("ovf_m4", mem[4], 20);
        chk("ovf_m5", mem[5], 30);

        // dst below src: bottom-up
        preload();
        run(2, 0, 4, dc, ec, nw, fa);
        chk("ovb_first_wa", fa, 0);
        chk("ovb_m0", mem[0], 20);
        chk("ovb_m1", mem[1], 30);
        chk("ovb_m2", mem[2], 40);
        chk("ovb_m3", mem[3], -64'd10);
        chk("ovb_m4", mem[4], 40);

        // out of bounds
        preload();
        run(30, 0, 3, dc, ec, nw, fa);
        chk("oob_err_cyc", ec, 2);
        chk("oob_done_cyc", dc, -1);
        chk("oob_we_cnt", nw, 0);
        chk("oob_busy", busy, 0);
        @(negedge clk);
        chk("oob_err_pulse", error, 0);
        chk("oob_m0", mem[0], 0);

        // exact fit at the top is legal
        run(29, 0, 3, dc, ec, nw, fa);
        chk("edge_done_cyc", dc, 8);
        chk("edge_m0", mem[0], 64'hDEAD_001D);

        // empty copy
        preload();
        run(0, 5, 0, dc, ec, nw, fa);
        chk("zero_done_cyc", dc, 2);
        chk("zero_we_cnt", nw, 0);
        chk("zero_m5", mem[5], -64'd10);

        // reset right after the second write commits
        preload();
        @(negedge clk);
        src_addr = 1;
        dst_addr = 20;
        length   = 4;
        start    = 1'b1;
        seen     = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (WE_mem) seen++;
            if (seen == 2) break;
        end
        chk("rstmid_reached", seen, 2);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_address", address, 0);
        chk("rstmid_we", WE_mem, 0);
        chk("rstmid_din", dIN, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_left", words_left, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_m20", mem[20], 10);
        chk("rstmid_m21", mem[21], 20);
        chk("rstmid_m22", mem[22], 64'hDEAD_0016);
        chk("rstmid_m23", mem[23], 64'hDEAD_0017);
        run(3, 22, 2, dc, ec, nw, fa);
        chk("rstmid_new_done", dc, 6);
        chk("rstmid_new_m22", mem[22], 30);
        chk("rstmid_new_m23", mem[23], 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
